// File: rtl/smart_house_pkg.sv
// Shared constants and slot field layout for the appliance scheduler.
// A 35-bit config word packs five 7-bit slots: {en, mode, dur[4:0]}.
package smart_house_pkg;

  localparam int unsigned CFG_W   = 35;
  localparam int unsigned NUM_DEV = 5;
  localparam int unsigned SLOT_W  = 7;
  localparam int unsigned DUR_W   = 5;

  localparam int unsigned EN_BIT   = 6;
  localparam int unsigned MODE_BIT = 5;
  localparam int unsigned DUR_LSB  = 0;

  localparam logic MODE_STEADY = 1'b0;
  localparam logic MODE_TIMED  = 1'b1;

  // Member order matches EN_BIT / MODE_BIT / DUR_LSB.
  typedef struct packed {
    logic             en;
    logic             mode;
    logic [DUR_W-1:0] dur;
  } slot_cfg_t;

endpackage

// File: rtl/dev_slot_timer.sv
// One appliance slot: latches its field on commit and owns the remaining-ticks
// counter that times out a timed-mode slot.
module dev_slot_timer
  import smart_house_pkg::*;
(
  input  logic      clk,
  input  logic      arst,
  input  logic      tick,
  input  logic      load,
  input  slot_cfg_t slot,
  output logic      on
);

  logic             r_en;
  logic             r_mode;
  logic [DUR_W-1:0] r_rem;
  logic             r_on;

  logic             w_en_d;
  logic             w_mode_d;
  logic [DUR_W-1:0] w_rem_d;
  logic             w_on_d;

  always_comb begin
    w_en_d   = r_en;
    w_mode_d = r_mode;
    w_rem_d  = r_rem;
    if (load) begin
      w_en_d   = slot.en;
      w_mode_d = slot.mode;
      w_rem_d  = slot.dur;
    end else if (tick && (r_rem != '0)) begin
      w_rem_d = r_rem - 1'b1;
    end
    // Output follows the next state so it changes on the commit/decrement edge.
    w_on_d = w_en_d && ((w_mode_d == MODE_STEADY) || (w_rem_d != '0));
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_en   <= 1'b0;
      r_mode <= 1'b0;
      r_rem  <= '0;
      r_on   <= 1'b0;
    end else begin
      r_en   <= w_en_d;
      r_mode <= w_mode_d;
      r_rem  <= w_rem_d;
      r_on   <= w_on_d;
    end
  end

  assign on = r_on;

endmodule

// File: rtl/device_scheduler.sv
// Double-buffered appliance scheduler: captures config writes into a pending
// register and commits them atomically on the next prescaler tick.
module device_scheduler
  import smart_house_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               write_en,
  input  logic [CFG_W-1:0]   configin,
  output logic [NUM_DEV-1:0] dev_on,
  output logic [CFG_W-1:0]   cfg_q,
  output logic               busy,
  output logic               applied
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [PW-1:0]    r_presc;
  logic [CFG_W-1:0] r_pend_cfg;
  logic             r_pend;
  logic [CFG_W-1:0] r_active;
  logic             r_applied;

  logic             w_tick;
  logic             w_commit;
  slot_cfg_t        w_slot [NUM_DEV];

  assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
  // Only a word already pending before this edge may commit.
  assign w_commit = w_tick && r_pend;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_presc    <= '0;
      r_pend_cfg <= '0;
      r_pend     <= 1'b0;
      r_active   <= '0;
      r_applied  <= 1'b0;
    end else begin
      r_presc   <= w_tick ? '0 : r_presc + 1'b1;
      r_applied <= w_commit;
      if (w_commit) begin
        r_active <= r_pend_cfg;
      end
      if (write_en) begin
        r_pend_cfg <= configin;
        r_pend     <= 1'b1;
      end else if (w_commit) begin
        r_pend <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_DEV; i++) begin : g_slot
    assign w_slot[i] = slot_cfg_t'(r_pend_cfg[i*SLOT_W +: SLOT_W]);

    dev_slot_timer u_slot (
      .clk  (clk),
      .arst (arst),
      .tick (w_tick),
      .load (w_commit),
      .slot (w_slot[i]),
      .on   (dev_on[i])
    );
  end

  assign cfg_q   = r_active;
  assign busy    = r_pend;
  assign applied = r_applied;

endmodule

// File: tb/tb_device_scheduler.sv
// Bench for device_scheduler: vector table, directed multi-cycle sequences and
// random traffic checked against a tick-count reference model.
module tb_device_scheduler;

  localparam int unsigned TD = 4;

  typedef struct {
    logic        we;
    logic [34:0] cfg;
    logic [4:0]  dev;
    logic [34:0] cq;
    logic        busy;
    logic        app;
  } vec_t;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        write_en = 1'b0;
  logic [34:0] configin = '0;
  logic [4:0]  dev_on;
  logic [34:0] cfg_q;
  logic        busy;
  logic        applied;

  always #5 clk = ~clk;

  device_scheduler #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .arst     (arst),
    .write_en (write_en),
    .configin (configin),
    .dev_on   (dev_on),
    .cfg_q    (cfg_q),
    .busy     (busy),
    .applied  (applied)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset, ticks seen, tick index of last commit.
  int          m_n, m_tickn, m_ctick;
  logic        m_pend, m_applied;
  logic [34:0] m_pword, m_active;

  task automatic chk(input string name, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] model_on();
    logic [4:0] r;
    logic [6:0] s;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      s = m_active[7*i +: 7];
      // A timed slot committed at tick k is on while fewer than dur ticks have passed.
      r[i] = s[6] && (!s[5] || (m_tickn < m_ctick + int'(s[4:0])));
    end
    return r;
  endfunction

  task automatic model_reset();
    m_n = 0; m_tickn = 0; m_ctick = 0;
    m_pend = 1'b0; m_applied = 1'b0;
    m_pword = '0; m_active = '0;
  endtask

  task automatic model_edge(input logic we, input logic [34:0] cfg);
    logic tick, commit;
    m_n++;
    tick = (m_n % TD) == 0;
    commit = tick && m_pend;
    m_applied = commit;
    if (tick) m_tickn++;
    if (commit) begin
      m_active = m_pword;
      m_ctick = m_tickn;
    end
    if (we) begin
      m_pword = cfg;
      m_pend = 1'b1;
    end else if (commit) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic step(input logic we, input logic [34:0] cfg);
    write_en = we;
    configin = cfg;
    @(posedge clk);
    #1;
    model_edge(we, cfg);
    write_en = 1'b0;
    chk("dev_on", 35'(dev_on), 35'(model_on()));
    chk("cfg_q", cfg_q, m_active);
    chk("busy", 35'(busy), 35'(m_pend));
    chk("applied", 35'(applied), 35'(m_applied));
  endtask

  // Asserts reset between edges, checks it takes effect at once, holds it with
  // write pulses, then releases on a falling edge.
  task automatic do_reset();
    logic [63:0] r;
    #2;
    arst = 1'b0;
    #1;
    chk("rst_dev_on", 35'(dev_on), 35'd0);
    chk("rst_cfg_q", cfg_q, 35'd0);
    chk("rst_busy", 35'(busy), 35'd0);
    chk("rst_applied", 35'(applied), 35'd0);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      r = {$urandom, $urandom};
      write_en = 1'b1;
      configin = r[34:0];
      @(posedge clk);
      #1;
      chk("rst_hold_dev_on", 35'(dev_on), 35'd0);
      chk("rst_hold_busy", 35'(busy), 35'd0);
      chk("rst_hold_applied", 35'(applied), 35'd0);
      chk("rst_hold_cfg_q", cfg_q, 35'd0);
    end
    write_en = 1'b0;
    configin = '0;
    @(negedge clk);
    arst = 1'b1;
  endtask

  localparam logic [34:0] W_STEADY = 35'b100001000010000001110;
  localparam logic [34:0] W_T3     = 35'b1100011;
  localparam logic [34:0] W_T0     = 35'b1100000;
  localparam logic [34:0] W_T20    = 35'b1110100;
  localparam logic [34:0] W_S0     = 35'b1000000;
  localparam logic [34:0] W_S1     = 35'b1000000 << 7;
  localparam logic [34:0] W_S3     = 35'b1000000 << 21;
  localparam logic [34:0] W_S4     = 35'b1000000 << 28;

  initial begin
    vec_t        tbl [6];
    int          cnt_on, cnt_app;
    logic [63:0] r;

    tbl[0] = '{1'b1, W_STEADY, 5'b00000, 35'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 35'd0, 5'b00000, 35'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 35'd0, 5'b00000, 35'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 35'd0, 5'b00100, W_STEADY, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 35'd0, 5'b00100, W_STEADY, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 35'd0, 5'b00100, W_STEADY, 1'b0, 1'b0};

    // Reset, then idle: nothing may turn on without a write.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b0, '0);
    chk("idle_dev_on", 35'(dev_on), 35'd0);

    // Steady commit from the vector table.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(tbl[k].we, tbl[k].cfg);
      chk("tbl_dev_on", 35'(dev_on), 35'(tbl[k].dev));
      chk("tbl_cfg_q", cfg_q, tbl[k].cq);
      chk("tbl_busy", 35'(busy), 35'(tbl[k].busy));
      chk("tbl_applied", 35'(applied), 35'(tbl[k].app));
    end

    // Timed slot, dur=3: on for exactly 3 ticks.
    do_reset();
    step(1'b1, W_T3);
    cnt_on = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, '0);
      cnt_on += int'(dev_on[0]);
    end
    chk_int("timed3_on_cycles", cnt_on, 3 * TD);

    // Timed slot, dur=0: commits but never turns on.
    do_reset();
    step(1'b1, W_T0);
    cnt_on = 0;
    cnt_app = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0, '0);
      cnt_on += int'(dev_on[0]);
      cnt_app += int'(applied);
    end
    chk_int("timed0_on_cycles", cnt_on, 0);
    chk_int("timed0_applied", cnt_app, 1);

    // Last write wins before the tick.
    do_reset();
    step(1'b1, W_S1);
    step(1'b0, '0);
    step(1'b1, W_S4);
    cnt_app = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0);
      cnt_app += int'(applied);
    end
    chk("lww_dev_on", 35'(dev_on), 35'(5'b10000));
    chk_int("lww_applied", cnt_app, 1);

    // Write coincident with a tick while a word is pending.
    do_reset();
    step(1'b1, W_S0);
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, W_S3);
    chk("coinc_cfg_q_old", cfg_q, W_S0);
    chk("coinc_busy", 35'(busy), 35'd1);
    chk("coinc_applied1", 35'(applied), 35'd1);
    chk("coinc_dev_on1", 35'(dev_on), 35'(5'b00001));
    for (int k = 0; k < 3; k++) step(1'b0, '0);
    chk("coinc_gap_applied", 35'(applied), 35'd0);
    step(1'b0, '0);
    chk("coinc_cfg_q_new", cfg_q, W_S3);
    chk("coinc_applied2", 35'(applied), 35'd1);
    chk("coinc_busy_clr", 35'(busy), 35'd0);
    chk("coinc_dev_on2", 35'(dev_on), 35'(5'b01000));

    // Asynchronous reset in the middle of a dur=20 run.
    do_reset();
    step(1'b1, W_T20);
    for (int k = 0; k < 10; k++) step(1'b0, '0);
    chk("midrun_on_before_rst", 35'(dev_on[0]), 35'd1);
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b0, '0);
    chk("midrun_off_after_rst", 35'(dev_on), 35'd0);

    // Re-commit the same dur=20 word five ticks in: 25 ticks on in total.
    do_reset();
    step(1'b1, W_T20);
    cnt_on = int'(dev_on[0]);
    for (int k = 0; k < 19; k++) begin
      step(1'b0, '0);
      cnt_on += int'(dev_on[0]);
    end
    step(1'b1, W_T20);
    cnt_on += int'(dev_on[0]);
    for (int k = 0; k < 99; k++) begin
      step(1'b0, '0);
      cnt_on += int'(dev_on[0]);
    end
    chk_int("recommit_on_cycles", cnt_on, 25 * TD);

    // Random traffic with occasional mid-run resets.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      r = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 5) == 0, r[34:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/device_scheduler.md
Name: device_scheduler

Overview:
- Downstream consumer of ControlUnit: takes the 35-bit configuration word it writes (configout qualified by write_en) and turns it into per-appliance on/off drive signals.
- Double-buffered: an accepted config is held pending and committed atomically on the next scheduler tick, so appliances never see a half-applied word.
- Supports steady-on and timed-on modes for 5 appliance slots, with busy and applied status back to the control path.

Parameters:
- TICK_DIV, 50: clk cycles per scheduler tick; legal range is 2 or more. The bench uses 4.
- NUM_DEV, 5: appliance slots. Fixed, because 5 x 7 bits = 35.
- DUR_W, 5: width of the per-slot duration field in ticks.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- arst  input  1  reset. Asynchronous and active-low: 0 resets.
- write_en  input  1  one-cycle strobe from ControlUnit; configin is valid in that cycle.
- configin  input  35  configuration word (ControlUnit configout).
- dev_on  output  5  appliance drive; bit i is slot i.
- cfg_q  output  35  active (committed) configuration, for readback.
- busy  output  1  a pending config is waiting for a tick.
- applied  output  1  one-cycle pulse after a commit.

Behaviour:
- Reset (arst=0, asynchronous): clears prescaler, pending register, pend flag, active register, all remaining counters, dev_on, busy and applied to 0. Reset during a timed run drops dev_on to 0 immediately. After reset release, nothing turns on until a new write_en is followed by a commit.
- Slot layout: slot i = configin[7i+6:7i].
  - bit 6 = en.
  - bit 5 = mode: 0 = steady, 1 = timed.
  - bits 4:0 = dur, unsigned, in ticks.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high in the cycle where the count equals TICK_DIV-1. It is internal and free-running from reset release.
- Capture: write_en=1 loads configin into the pending register and sets pend at that clock edge. A write_en while pend is already set overwrites the pending register (last write wins, no error).
- Commit, on an edge where tick=1 and pend was already 1 before that edge:
  - Active register is loaded from the pending register.
  - pend is cleared.
  - Each slot's remaining counter is loaded with dur.
  - applied=1 in the following cycle only.
- Simultaneous write_en and tick:
  - If pend was 1: the old pending word is committed; the new word is captured; pend stays 1.
  - If pend was 0: no commit; the new word waits for the next tick.
- busy equals pend, registered.
- Worst-case latency from write_en to a dev_on change is TICK_DIV+1 cycles.
- Per-slot output, registered and updated on the same edge as the commit or decrement:
  - en=0: off.
  - en=1, mode=0: on (steady); dur is ignored.
  - en=1, mode=1: on while remaining is not 0. remaining decrements by 1 on each tick after the commit tick and saturates at 0. The slot is therefore on for exactly dur ticks.
  - en=1, mode=1, dur=0: off.
- Re-commit mid-run: remaining counters reload from the new word, so a timed slot restarts. There is no carry-over.
- cfg_q reflects the active register. Bits beyond 35 do not exist; there is no arithmetic overflow, because counters only decrement and saturate.

Decomposition:
- Package smart_house_pkg holds:
  - constants CFG_W=35, NUM_DEV=5, SLOT_W=7, DUR_W=5;
  - field offsets EN_BIT=6, MODE_BIT=5, DUR_LSB=0;
  - localparams MODE_STEADY=0, MODE_TIMED=1.
- Sub-module dev_slot_timer, instantiated 5 times:
  - inputs: clk, arst, tick, load, slot field;
  - output: on.
  - It owns the remaining counter.
- The top level owns the prescaler, the pending/active registers, pend, and the applied logic.

Test Plan (TICK_DIV=4):
- Reset: hold arst=0 with write_en pulses -> dev_on=0, cfg_q=0, busy=0, applied=0. Release arst -> dev_on stays 0.
- Steady commit: write_en with configin=35'b100001000010000001110. Slot 2 has en=1, mode=0; slots 0, 1 and 3+ are off. Required response:
  - busy=1 next cycle;
  - at the next tick, dev_on=5'b00100 and cfg_q equals the word;
  - applied pulses exactly one cycle;
  - busy=0.
- Timed slot: slot0=7'b1100011 (en=1, timed, dur=3) -> dev_on[0]=1 for exactly 12 cycles (3 ticks) after the commit, then 0. Repeat with dur=0 -> dev_on[0] never rises.
- Last-write-wins: two write_en pulses 1 cycle apart before a tick, first enabling slot 1 steady, second enabling slot 4 steady -> after the tick, dev_on=5'b10000 and only one applied pulse.
- Write coincident with tick while pend=1: the old word commits (check cfg_q), busy stays 1, and the new word commits on the following tick (second applied pulse 4 cycles later).
- Mid-run: during a dur=20 timed run, drive arst=0 asynchronously between clock edges -> dev_on[0]=0 immediately. Separately, re-commit the same word at tick 5 -> the slot remains on for 20 more ticks.
